// File: rtl/output_port_scheduler.sv
// output_port_scheduler
//   Per-output-port flit scheduler for the wormhole VC router (one instance per
//   output port). Round-robin arbitration among the input ports requesting this
//   output, filtered by downstream on/off flow control. Drives the crossbar
//   select combinationally and a registered valid_flit toward the next router.
//
//   Optional build macro: PACKET_LOCK_EN
//     defined   -> IDLE/LOCKED FSM keeps the output on one input for a whole
//                  packet (head .. tail).
//     undefined -> flit-level interleaving, no FSM (dbg_locked_o tied to 0).
//
// Ports
//   clk           clock, all state on rising edge
//   rst           asynchronous reset, active-low
//   req_i         [PORT_NUM]      input port p has a flit for this output
//   ds_vc_i       [PORT_NUM][VW]  downstream VC id of port p's flit
//   tail_i        [PORT_NUM]      port p's flit is a tail (or head-tail)
//   on_off_i      [VC_NUM]        downstream VC v can accept a flit
//   grant_o       [PORT_NUM]      one-hot grant, combinational
//   xbar_sel_o    [PW]            index of granted port, 0 when no grant
//   valid_flit_o                  registered: flit launched last cycle
//   ds_vc_o       [VW]            registered: VC id of launched flit
//   stall_o                       registered: starvation indication
//   dbg_ptr_o     [PW]            round-robin pointer (debug)
//   dbg_locked_o                  lock FSM is in LOCKED (debug)
//
// Handshake: a flit moves from input p in cycle T exactly when req_i[p] and
// grant_o[p] are both high in T; req_i is a request that may be held across
// cycles, grant_o is the acceptance and there is no later cancel.
module output_port_scheduler #(
  parameter int PORT_NUM    = 5,
  parameter int VC_NUM      = 2,
  parameter int STALL_LIMIT = 15,
  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1,
  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int SW = $clog2(STALL_LIMIT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORT_NUM-1:0]          req_i,
  input  logic [PORT_NUM-1:0][VW-1:0]  ds_vc_i,
  input  logic [PORT_NUM-1:0]          tail_i,
  input  logic [VC_NUM-1:0]            on_off_i,
  output logic [PORT_NUM-1:0]          grant_o,
  output logic [PW-1:0]                xbar_sel_o,
  output logic                         valid_flit_o,
  output logic [VW-1:0]                ds_vc_o,
  output logic                         stall_o,
  output logic [PW-1:0]                dbg_ptr_o,
  output logic                         dbg_locked_o
);

  logic [PW-1:0]       ptr;
  logic [PW-1:0]       ptr_nxt;
  logic [PORT_NUM-1:0] elig;
  logic [PW-1:0]       scan_idx;
  logic [PW-1:0]       gnt_idx;
  logic                any_gnt;
  logic                count_en;
  logic [SW-1:0]       stall_cnt;
  logic [SW-1:0]       stall_nxt;

`ifdef PACKET_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;
  lock_state_t   state;
  logic [PW-1:0] owner;
  logic          unused_tail;
  assign unused_tail = 1'b0;
`else
  // Packet integrity is the VC allocator's job here, so tail is not needed.
  logic unused_tail;
  assign unused_tail = ^tail_i;
`endif

  always_comb begin
    elig     = '0;
    scan_idx = '0;
    gnt_idx  = '0;
    any_gnt  = 1'b0;
    grant_o  = '0;

    // Gating with rst keeps grant_o low while the block is held in reset.
    // VC ids outside 0..VC_NUM-1 are never eligible.
    for (int p = 0; p < PORT_NUM; p++) begin
      if (req_i[p] && rst && (int'(ds_vc_i[p]) < VC_NUM)) begin
        elig[p] = on_off_i[ds_vc_i[p]];
      end
`ifdef PACKET_LOCK_EN
      if ((state == LOCKED) && (PW'(p) != owner)) begin
        elig[p] = 1'b0;
      end
`endif
    end

    // First eligible port scanning ptr, ptr+1, ... modulo PORT_NUM.
    for (int i = 0; i < PORT_NUM; i++) begin
      scan_idx = PW'((int'(ptr) + i) % PORT_NUM);
      if (!any_gnt && elig[scan_idx]) begin
        any_gnt           = 1'b1;
        gnt_idx           = scan_idx;
        grant_o[scan_idx] = 1'b1;
      end
    end

    ptr_nxt = (gnt_idx == PW'(PORT_NUM - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef PACKET_LOCK_EN
    // While locked only the owner being blocked counts as starvation.
    if (state == LOCKED) count_en = req_i[owner] && !any_gnt;
    else                 count_en = (|req_i) && !any_gnt;
`else
    count_en = (|req_i) && !any_gnt;
`endif

    if (!count_en)                         stall_nxt = '0;
    else if (stall_cnt == SW'(STALL_LIMIT)) stall_nxt = stall_cnt;
    else                                   stall_nxt = stall_cnt + 1'b1;
  end

  assign xbar_sel_o = gnt_idx;
  assign dbg_ptr_o  = ptr;
`ifdef PACKET_LOCK_EN
  assign dbg_locked_o = (state == LOCKED);
`else
  assign dbg_locked_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= '0;
      valid_flit_o <= 1'b0;
      ds_vc_o      <= '0;
      stall_cnt    <= '0;
      stall_o      <= 1'b0;
`ifdef PACKET_LOCK_EN
      state        <= IDLE;
      owner        <= '0;
`endif
    end else begin
      valid_flit_o <= any_gnt;
      if (any_gnt) ds_vc_o <= ds_vc_i[gnt_idx];
      stall_cnt <= stall_nxt;
      stall_o   <= (stall_nxt == SW'(STALL_LIMIT));
`ifdef PACKET_LOCK_EN
      // Pointer only advances when a packet completes, so a locked packet
      // does not skew fairness for the next round.
      case (state)
        IDLE: begin
          if (any_gnt) begin
            if (tail_i[gnt_idx]) begin
              ptr <= ptr_nxt;
            end else begin
              state <= LOCKED;
              owner <= gnt_idx;
            end
          end
        end
        LOCKED: begin
          if (any_gnt && tail_i[gnt_idx]) begin
            state <= IDLE;
            ptr   <= ptr_nxt;
          end
        end
        default: state <= IDLE;
      endcase
`else
      if (any_gnt) ptr <= ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_output_port_scheduler.sv
// Directed bench for output_port_scheduler (STALL_LIMIT=3). Inputs change on
// the falling edge; combinational outputs are sampled 1 ns later, registered
// outputs 1 ns after the following rising edge.
module tb_output_port_scheduler;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      req;
  logic [4:0][0:0] ds_vc;
  logic [4:0]      tail;
  logic [1:0]      on_off;
  logic [4:0]      grant;
  logic [2:0]      xbar_sel;
  logic            valid_flit;
  logic [0:0]      ds_vc_out;
  logic            stall;
  logic [2:0]      dbg_ptr;
  logic            dbg_locked;

  int checks   = 0;
  int failures = 0;
  int exp_seq[7];
  int sent;

  always #5 clk = ~clk;

  output_port_scheduler #(
    .PORT_NUM    (5),
    .VC_NUM      (2),
    .STALL_LIMIT (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .ds_vc_i      (ds_vc),
    .tail_i       (tail),
    .on_off_i     (on_off),
    .grant_o      (grant),
    .xbar_sel_o   (xbar_sel),
    .valid_flit_o (valid_flit),
    .ds_vc_o      (ds_vc_out),
    .stall_o      (stall),
    .dbg_ptr_o    (dbg_ptr),
    .dbg_locked_o (dbg_locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: g is the expected granted port (-1 = none); exp_stall and
  // exp_vc are the registered values expected after the rising edge.
  task automatic cyc(input string tag, input int g, input logic exp_stall, input logic exp_vc);
    logic [31:0] exp_gnt;
    logic [31:0] exp_sel;
    exp_gnt = (g < 0) ? 32'd0 : (32'd1 << g);
    exp_sel = (g < 0) ? 32'd0 : 32'(g);
    #1;
    chk({tag, "_grant"}, 32'(grant), exp_gnt);
    chk({tag, "_sel"}, 32'(xbar_sel), exp_sel);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(valid_flit), (g < 0) ? 32'd0 : 32'd1);
    chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    chk({tag, "_dsvc"}, 32'(ds_vc_out), 32'(exp_vc));
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b0;
    req    = '0;
    tail   = '0;
    ds_vc  = '0;
    on_off = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(valid_flit), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ptr", 32'(dbg_ptr), 32'd0);
    chk("rst_locked", 32'(dbg_locked), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc("idle", -1, 1'b0, 1'b0);

    // Round-robin fairness: all request, all on, all single-flit
    req    = 5'b11111;
    on_off = 2'b11;
    tail   = 5'b11111;
    for (int i = 0; i < 12; i++) cyc("rr", i % 5, 1'b0, 1'b0);

    // Reset asserted mid-traffic acts immediately
    rst = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_sel", 32'(xbar_sel), 32'd0);
    chk("mid_rst_valid", 32'(valid_flit), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_ptr", 32'(dbg_ptr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    cyc("post_rst", -1, 1'b0, 1'b0);
    chk("post_rst_ptr", 32'(dbg_ptr), 32'd0);

    // Flow control: p1 on VC0 (off), p2 on VC1 (on)
    req      = 5'b00110;
    ds_vc[1] = 1'b0;
    ds_vc[2] = 1'b1;
    on_off   = 2'b10;
    for (int i = 0; i < 3; i++) cyc("fc_off", 2, 1'b0, 1'b1);
    chk("fc_ptr", 32'(dbg_ptr), 32'd3);
    on_off = 2'b11;
    cyc("fc_on0", 1, 1'b0, 1'b0);
    cyc("fc_on1", 2, 1'b0, 1'b1);
    cyc("fc_on2", 1, 1'b0, 1'b0);
    cyc("fc_on3", 2, 1'b0, 1'b1);

    // Stall: p0 blocked, saturating counter, release
    req    = 5'b00001;
    ds_vc  = '0;
    on_off = 2'b00;
    cyc("st_b1", -1, 1'b0, 1'b1);
    cyc("st_b2", -1, 1'b0, 1'b1);
    cyc("st_b3", -1, 1'b1, 1'b1);
    cyc("st_b4", -1, 1'b1, 1'b1);
    on_off = 2'b01;
    cyc("st_rel", 0, 1'b0, 1'b0);
    chk("st_ptr", 32'(dbg_ptr), 32'd1);

    // Stall counter clears when nobody requests
    on_off = 2'b00;
    cyc("sc_b1", -1, 1'b0, 1'b0);
    cyc("sc_b2", -1, 1'b0, 1'b0);
    req = '0;
    cyc("sc_idle", -1, 1'b0, 1'b0);
    req = 5'b00001;
    cyc("sc_c1", -1, 1'b0, 1'b0);
    cyc("sc_c2", -1, 1'b0, 1'b0);
    cyc("sc_c3", -1, 1'b1, 1'b0);
    req = '0;
    cyc("sc_clr", -1, 1'b0, 1'b0);

    // Pointer wrap with p0 and p4 requesting (ptr=1)
    req    = 5'b10001;
    on_off = 2'b11;
    cyc("wrap0", 4, 1'b0, 1'b0);
    cyc("wrap1", 0, 1'b0, 1'b0);
    cyc("wrap2", 4, 1'b0, 1'b0);
    cyc("wrap3", 0, 1'b0, 1'b0);

    // p1 sends head/body/tail while p3 requests; on_off drops in cycle 2
`ifdef PACKET_LOCK_EN
    exp_seq = '{1, 1, -1, 1, 3, 3, 3};
`else
    exp_seq = '{1, 3, -1, 1, 3, 1, 3};
`endif
    sent = 0;
    for (int c = 0; c < 7; c++) begin
      req    = {1'b0, 1'b1, 1'b0, (sent < 3), 1'b0};
      tail   = {1'b0, 1'b1, 1'b0, (sent == 2), 1'b0};
      on_off = (c == 2) ? 2'b00 : 2'b11;
      cyc("pkt", exp_seq[c], 1'b0, 1'b0);
      if (exp_seq[c] == 1) sent++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_port_scheduler.md
Name: output_port_scheduler

Overview:
- Per-output-port flit scheduler for the wormhole VC router; one instance per output port (LOCAL, NORTH, SOUTH, WEST, EAST).
- Arbitrates among the PORT_NUM input ports requesting this output, filtered by downstream on/off flow control.
- Drives the crossbar select for this output and the registered valid_flit toward the downstream router.
- Optionally locks the output to one input for a whole packet.

Parameters:
- PORT_NUM, 5, number of requesting input ports.
- VC_NUM, 2, number of downstream VCs on this output.
- STALL_LIMIT, 15, consecutive blocked cycles before stall_o asserts; STALL_LIMIT >= 1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-low.
- req_i  input  PORT_NUM  input port p has a flit for this output.
- ds_vc_i  input  PORT_NUM x $clog2(VC_NUM)  downstream VC id of port p's flit.
- tail_i  input  PORT_NUM  port p's flit is a tail (head-tail single flit also sets it).
- on_off_i  input  VC_NUM  downstream VC v can accept a flit (1 = on).
- grant_o  output  PORT_NUM  one-hot grant, combinational, same cycle as request.
- xbar_sel_o  output  $clog2(PORT_NUM)  index of granted port, combinational; 0 when no grant.
- valid_flit_o  output  1  registered: flit launched last cycle.
- ds_vc_o  output  $clog2(VC_NUM)  registered: VC id of the launched flit.
- stall_o  output  1  registered: starvation indication.

Behaviour:
- Reset (rst=0, async): ptr=0, valid_flit_o=0, ds_vc_o=0, stall_cnt=0, stall_o=0, lock state IDLE, owner=0. grant_o is combinational and is therefore 0 during reset.
- Eligibility (cycle T): elig[p] = req_i[p] & on_off_i[ds_vc_i[p]].
- Round-robin arbitration: grant the first eligible p scanning ptr, ptr+1, ..., wrapping modulo PORT_NUM.
- At most one grant bit per cycle.
- Pointer update: on any grant to p, ptr <= (p+1) mod PORT_NUM at the T edge. With no grant, ptr holds.
- Output register: valid_flit_o <= |grant_o; ds_vc_o <= ds_vc_i[granted] (holds when there is no grant). Grant-to-valid latency is 1 cycle.
- Stall counter, width $clog2(STALL_LIMIT+1):
  - Increments, saturating at STALL_LIMIT, in cycles with |req_i=1 and no grant.
  - Clears on any grant or when |req_i=0.
  - stall_o <= (next stall_cnt == STALL_LIMIT).
- on_off_i falling in the same cycle as a request: the request is ineligible that cycle. There is no retroactive cancel of a flit already granted.
- Requests with ds_vc_i >= VC_NUM (non-power-of-2 VC_NUM) are ineligible.

Optional Feature:
- Macro: PACKET_LOCK_EN.
- Defined: 2-state FSM, IDLE and LOCKED.
  - IDLE: round-robin as above. A grant to p with tail_i[p]=0 moves to LOCKED with owner=p.
  - LOCKED: only owner is eligible (still subject to on_off). Other requesters get no grant even when the output is free.
  - Granting owner with tail_i=1 returns to IDLE.
  - ptr updates only on the transition back to IDLE, or on single-flit grants from IDLE.
  - Stall counter counts only when owner is blocked or, in IDLE, when all requesters are blocked.
- Undefined: flit-level interleaving, no FSM. Packet integrity is guaranteed per downstream VC by the VC allocator.

Test Plan:
- Reset/idle: rst=0 mid-traffic -> grant_o=0, valid_flit_o=0, stall_o=0 immediately. After release with req_i=0 -> no grant, ptr=0.
- Round-robin fairness: req_i=5'b11111, all on_off=1, all tail=1, 10 cycles -> grants p0,1,2,3,4,0,1,2,3,4. valid_flit_o=1 from cycle 2 onward; xbar_sel_o matches grant.
- Flow control: req_i=5'b00110, ds_vc_i[1]=0, ds_vc_i[2]=1, on_off_i=2'b10 -> only p2 granted each cycle. Set on_off_i=2'b11 -> p1 and p2 alternate.
- Stall: STALL_LIMIT=3, req_i=5'b00001, on_off_i=0 -> stall_o=1 after the 3rd blocked cycle. on_off_i=1 -> grant p0, stall_o=0 next cycle.
- Wrap/pointer: after a grant to p4 with req_i=5'b10001 -> next grant p0, then p4.
- PACKET_LOCK_EN: p1 sends head,body,tail while p3 requests continuously -> p1 granted 3 consecutive cycles (with a gap if on_off drops), then p3. Undefined macro -> p1 and p3 alternate.
